// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: receiver FSM state encoding, data
//               width and a helper to derive clocks-per-bit from the clock
//               frequency and baud rate.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int c_DATA_W = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_RXDATA = 3'd2,
    S_STOP   = 3'd3,
    S_BREAK  = 3'd4
  } rx_state_e;

  // Rounded to the nearest integer so the bit period error stays below half
  // a clock.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + (baud / 2)) / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ============================================================================
// Module      : uart_sync2
// Description : Two-flop synchronizer for a single asynchronous input.
//               The reset value is a parameter so that idle-high lines do
//               not look like activity while coming out of reset.
// Ports       : i_clk   - destination clock
//               i_rst_n - asynchronous active-low reset
//               i_d     - asynchronous input
//               o_q     - synchronized output
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : UART receiver, 8N1, LSB first, mid-bit sampling with start
//               bit glitch rejection. Bytes are delivered on a single-entry
//               AXI-Stream master register; framing errors and overruns are
//               reported as one-cycle pulses.
// Ports       : i_clk           - system clock
//               i_rst_n         - asynchronous active-low reset
//               i_rxd           - asynchronous serial input, idle high
//               o_m_axis_tvalid - received byte available
//               i_m_axis_tready - downstream accepts byte
//               o_m_axis_tdata  - received byte
//               o_rxd_busy      - frame reception in progress
//               o_frame_err     - pulse: stop bit sampled low
//               o_overrun       - pulse: completed byte dropped (register full)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_rxd,
  output logic                o_m_axis_tvalid,
  input  logic                i_m_axis_tready,
  output logic [c_DATA_W-1:0] o_m_axis_tdata,
  output logic                o_rxd_busy,
  output logic                o_frame_err,
  output logic                o_overrun
);

  localparam int                 c_CNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [c_CNT_W-1:0] c_HALF    = c_CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

  logic                w_rxd_s;
  rx_state_e           r_state;
  rx_state_e           w_state_nxt;
  logic [c_CNT_W-1:0]  r_clk_count;
  logic [c_CNT_W-1:0]  w_clk_count_nxt;
  logic [2:0]          r_bit_idx;
  logic [2:0]          w_bit_idx_nxt;
  logic [c_DATA_W-1:0] r_shift;
  logic [c_DATA_W-1:0] r_tdata;
  logic                r_tvalid;
  logic                r_frame_err;
  logic                r_overrun;
  logic                w_sample_bit;
  logic                w_deliver;
  logic                w_stop_bad;

  uart_sync2 #(
    .RST_VAL (1'b1)
  ) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_rxd),
    .o_q     (w_rxd_s)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_clk_count <= '0;
      r_bit_idx   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_clk_count <= w_clk_count_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_clk_count_nxt = r_clk_count;
    w_bit_idx_nxt   = r_bit_idx;
    w_sample_bit    = 1'b0;
    w_deliver       = 1'b0;
    w_stop_bad      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_clk_count_nxt = '0;
        w_bit_idx_nxt   = '0;
        if (!w_rxd_s) w_state_nxt = S_START;
      end
      S_START: begin
        // Recheck the line half a bit in; a high level means the falling
        // edge was a glitch and is silently ignored.
        if (r_clk_count == c_HALF) begin
          w_clk_count_nxt = '0;
          w_state_nxt     = w_rxd_s ? S_IDLE : S_RXDATA;
        end else begin
          w_clk_count_nxt = r_clk_count + c_CNT_ONE;
        end
      end
      S_RXDATA: begin
        if (r_clk_count == c_CNT_MAX) begin
          w_clk_count_nxt = '0;
          w_sample_bit    = 1'b1;
          if (r_bit_idx == 3'd7) begin
            w_bit_idx_nxt = '0;
            w_state_nxt   = S_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end else begin
          w_clk_count_nxt = r_clk_count + c_CNT_ONE;
        end
      end
      S_STOP: begin
        // Return to IDLE right at mid stop bit so a start bit that follows
        // with no idle gap is still seen.
        if (r_clk_count == c_CNT_MAX) begin
          w_clk_count_nxt = '0;
          if (w_rxd_s) begin
            w_deliver   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_stop_bad  = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end else begin
          w_clk_count_nxt = r_clk_count + c_CNT_ONE;
        end
      end
      S_BREAK: begin
        // Wait for the line to recover so a held-low line yields one error.
        w_clk_count_nxt = '0;
        if (w_rxd_s) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift <= '0;
    end else if (w_sample_bit) begin
      r_shift[r_bit_idx] <= w_rxd_s;
    end
  end

  // Single-entry output register. A completed byte loads if the register
  // is empty or being drained this cycle; otherwise it is dropped and the
  // held byte stays untouched.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tdata     <= '0;
      r_tvalid    <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_stop_bad;
      r_overrun   <= 1'b0;
      if (w_deliver) begin
        if (!r_tvalid || i_m_axis_tready) begin
          r_tdata  <= r_shift;
          r_tvalid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_tvalid && i_m_axis_tready) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  assign o_m_axis_tvalid = r_tvalid;
  assign o_m_axis_tdata  = r_tdata;
  assign o_rxd_busy      = (r_state != S_IDLE);
  assign o_frame_err     = r_frame_err;
  assign o_overrun       = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx. A serial transmitter task
//               drives the line; a monitor collects accepted beats and error
//               pulses; expected results come from frame-level rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int CPB2 = 87;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       rxd, tready, tvalid, busy, ferr, ovr;
  logic [7:0] tdata;
  logic       rxd2, tready2, tvalid2, busy2, ferr2, ovr2;
  logic [7:0] tdata2;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_rxd           (rxd),
    .o_m_axis_tvalid (tvalid),
    .i_m_axis_tready (tready),
    .o_m_axis_tdata  (tdata),
    .o_rxd_busy      (busy),
    .o_frame_err     (ferr),
    .o_overrun       (ovr)
  );

  uart_rx #(.CLKS_PER_BIT(CPB2)) dut87 (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_rxd           (rxd2),
    .o_m_axis_tvalid (tvalid2),
    .i_m_axis_tready (tready2),
    .o_m_axis_tdata  (tdata2),
    .o_rxd_busy      (busy2),
    .o_frame_err     (ferr2),
    .o_overrun       (ovr2)
  );

  // ---------------- monitor ----------------
  logic [7:0] q_got[$];
  logic [7:0] q_got2[$];
  int n_ferr = 0, n_ovr = 0, n_ferr2 = 0, n_ovr2 = 0, n_stab = 0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    if (rst_n) begin
      if (tvalid && tready) q_got.push_back(tdata);
      if (ferr) n_ferr <= n_ferr + 1;
      if (ovr)  n_ovr  <= n_ovr + 1;
      if (prev_hold && (!tvalid || tdata != prev_data)) n_stab <= n_stab + 1;
      prev_hold <= tvalid && !tready;
      prev_data <= tdata;
      if (tvalid2 && tready2) q_got2.push_back(tdata2);
      if (ferr2) n_ferr2 <= n_ferr2 + 1;
      if (ovr2)  n_ovr2  <= n_ovr2 + 1;
    end else begin
      prev_hold <= 1'b0;
    end
  end

  // ---------------- helpers ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) rxd2 = v;
    else     rxd  = v;
  endtask

  // Serial transmitter: start, 8 data bits LSB first, stop (level given).
  task automatic send_frame(input bit sel, input int cpb, input logic [7:0] b, input logic stop_v);
    drive(sel, 1'b0);
    tick(cpb);
    for (int i = 0; i < 8; i++) begin
      drive(sel, b[i]);
      tick(cpb);
    end
    drive(sel, stop_v);
    tick(cpb);
  endtask

  task automatic idle(input int bits);
    rxd = 1'b1;
    tick(bits * CPB);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_v;
    int         exp_beats;
    int         exp_ferr;
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] q_exp[$];
  logic [7:0] rb;
  logic [7:0] b6b;
  logic       good;
  int         bf, bo, exp_ferr, gap;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 1, 0};
    vecs[3] = '{8'h5A, 1'b0, 0, 1};
    vecs[4] = '{8'h7E, 1'b1, 1, 0};
    vecs[5] = '{8'h01, 1'b1, 1, 0};

    rst_n = 1'b0; rxd = 1'b1; rxd2 = 1'b1; tready = 1'b1; tready2 = 1'b1;
    tick(3);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tdata", tdata, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_ferr", ferr, 0);
    chk("rst_ovr", ovr, 0);
    rst_n = 1'b1;
    tick(4);
    chk("idle_busy", busy, 0);

    // table-driven single frames
    for (int i = 0; i < 6; i++) begin
      q_got.delete(); bf = n_ferr; bo = n_ovr;
      send_frame(1'b0, CPB, vecs[i].data, vecs[i].stop_v);
      idle(2);
      chk($sformatf("vec%0d_beats", i), q_got.size(), vecs[i].exp_beats);
      if (q_got.size() > 0) chk($sformatf("vec%0d_data", i), q_got[0], vecs[i].data);
      chk($sformatf("vec%0d_ferr", i), n_ferr - bf, vecs[i].exp_ferr);
      chk($sformatf("vec%0d_ovr", i), n_ovr - bo, 0);
      chk($sformatf("vec%0d_busy", i), busy, 0);
    end

    // back-to-back frames with no idle gap
    q_got.delete(); bf = n_ferr;
    send_frame(1'b0, CPB, 8'h00, 1'b1);
    send_frame(1'b0, CPB, 8'hFF, 1'b1);
    send_frame(1'b0, CPB, 8'h55, 1'b1);
    idle(2);
    chk("b2b_beats", q_got.size(), 3);
    if (q_got.size() == 3) begin
      chk("b2b_d0", q_got[0], 8'h00);
      chk("b2b_d1", q_got[1], 8'hFF);
      chk("b2b_d2", q_got[2], 8'h55);
    end
    chk("b2b_ferr", n_ferr - bf, 0);

    // start-bit glitch
    q_got.delete(); bf = n_ferr;
    rxd = 1'b0; tick(5); rxd = 1'b1; tick(3 * CPB);
    chk("glitch_beats", q_got.size(), 0);
    chk("glitch_ferr", n_ferr - bf, 0);
    chk("glitch_busy", busy, 0);
    send_frame(1'b0, CPB, 8'h3C, 1'b1);
    idle(2);
    chk("glitch_next_beats", q_got.size(), 1);
    if (q_got.size() > 0) chk("glitch_next_data", q_got[0], 8'h3C);

    // framing error followed by a long break
    q_got.delete(); bf = n_ferr;
    send_frame(1'b0, CPB, 8'h81, 1'b0);
    tick(20 * CPB);
    chk("break_busy", busy, 1);
    tick(20 * CPB);
    chk("break_ferr", n_ferr - bf, 1);
    idle(2);
    chk("break_exit_busy", busy, 0);
    chk("break_beats", q_got.size(), 0);
    send_frame(1'b0, CPB, 8'h12, 1'b1);
    idle(2);
    chk("break_next_beats", q_got.size(), 1);
    if (q_got.size() > 0) chk("break_next_data", q_got[0], 8'h12);

    // overrun with backpressure
    q_got.delete(); bo = n_ovr; tready = 1'b0;
    send_frame(1'b0, CPB, 8'h11, 1'b1);
    idle(1);
    send_frame(1'b0, CPB, 8'h22, 1'b1);
    idle(2);
    chk("ovr_tvalid", tvalid, 1);
    chk("ovr_tdata", tdata, 8'h11);
    chk("ovr_pulses", n_ovr - bo, 1);
    chk("ovr_no_beat", q_got.size(), 0);
    tready = 1'b1;
    tick(4);
    chk("ovr_drain_beats", q_got.size(), 1);
    if (q_got.size() > 0) chk("ovr_drain_data", q_got[0], 8'h11);
    chk("ovr_drain_tvalid", tvalid, 0);

    // reset in the middle of a frame while a byte is pending
    tready = 1'b0; q_got.delete();
    send_frame(1'b0, CPB, 8'h47, 1'b1);
    idle(1);
    chk("mrst_pending", tvalid, 1);
    b6b = 8'h6B;
    rxd = 1'b0; tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rxd = b6b[i];
      tick(CPB);
    end
    rxd = b6b[4];
    tick(CPB / 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_tvalid", tvalid, 0);
    chk("mrst_tdata", tdata, 8'h00);
    chk("mrst_busy", busy, 0);
    rxd = 1'b1;
    tick(2);
    rst_n = 1'b1;
    bf = n_ferr; bo = n_ovr; tready = 1'b1;
    tick(2);
    send_frame(1'b0, CPB, 8'h9E, 1'b1);
    idle(2);
    chk("mrst_beats", q_got.size(), 1);
    if (q_got.size() > 0) chk("mrst_data", q_got[0], 8'h9E);
    chk("mrst_ferr", n_ferr - bf, 0);
    chk("mrst_ovr", n_ovr - bo, 0);

    // randomized frames against a frame-level reference model
    q_got.delete(); q_exp.delete(); bf = n_ferr; bo = n_ovr; exp_ferr = 0;
    for (int k = 0; k < 40; k++) begin
      rb   = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 9) != 0);
      send_frame(1'b0, CPB, rb, good);
      if (good) q_exp.push_back(rb);
      else      exp_ferr++;
      rxd = 1'b1;
      gap = good ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 3));
      tick(gap * CPB + int'($urandom_range(0, 7)));
    end
    idle(2);
    chk("rnd_count", q_got.size(), q_exp.size());
    for (int k = 0; k < q_exp.size() && k < q_got.size(); k++)
      chk($sformatf("rnd_data%0d", k), q_got[k], q_exp[k]);
    chk("rnd_ferr", n_ferr - bf, exp_ferr);
    chk("rnd_ovr", n_ovr - bo, 0);

    // CLKS_PER_BIT = 87 instance
    q_got2.delete();
    send_frame(1'b1, CPB2, 8'hA5, 1'b1);
    rxd2 = 1'b1;
    tick(2 * CPB2);
    chk("c87_beats", q_got2.size(), 1);
    if (q_got2.size() > 0) chk("c87_data", q_got2[0], 8'hA5);
    chk("c87_ferr", n_ferr2, 0);
    chk("c87_ovr", n_ovr2, 0);
    chk("c87_busy", busy2, 0);

    chk("tdata_stable_while_stalled", n_stab, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: 8 data bits, 1 start bit, 1 stop bit, no parity, LSB first.
- Sits on the serial input pin and delivers each received byte on an AXI-Stream master port.
- Loopback pairing: its i_rxd is driven directly by the transmitter's o_txd in the system bench.
- Mid-bit sampling, glitch rejection on the start bit, framing-error and overrun reporting.

Parameters:
- CLKS_PER_BIT, 87, i_clk cycles per UART bit (i_clk frequency / baud). Legal range 4..255.

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst_n  in  1  reset, asynchronous assert, active-low.
- i_rxd  in  1  asynchronous serial input; idle high.
- o_m_axis_tvalid  out  1  received byte available.
- i_m_axis_tready  in  1  downstream accepts byte.
- o_m_axis_tdata  out  8  received byte; stable while tvalid=1.
- o_rxd_busy  out  1  frame reception in progress.
- o_frame_err  out  1  one-cycle pulse: stop bit sampled low.
- o_overrun  out  1  one-cycle pulse: completed byte dropped because the output register was still full.

Behaviour:
- Reset (i_rst_n=0, async): FSM=IDLE, counters=0, shift reg=0, tvalid=0, tdata=0x00, busy=0, frame_err=0, overrun=0, synchronizer flops=1.
- Input path: i_rxd passes through a 2-flop synchronizer (rxd_s). All decisions use rxd_s only.
- Counter width: $clog2(CLKS_PER_BIT). Bit index: 3 bits.
- Half-bit point: HALF = (CLKS_PER_BIT-1)/2, integer division.
- State IDLE:
  - busy=0; clk_count=0; bit_idx=0.
  - rxd_s=0 -> START.
- State START:
  - clk_count increments each cycle.
  - At clk_count==HALF: if rxd_s=0 -> RXDATA with clk_count=0; if rxd_s=1, treat as a glitch -> IDLE. No error flag is raised for a glitch.
- State RXDATA:
  - At clk_count==CLKS_PER_BIT-1: shift_reg[bit_idx] <= rxd_s; clk_count=0.
  - bit_idx==7 -> STOP with bit_idx=0; otherwise bit_idx+1.
  - Each sample therefore lands at mid-bit.
- State STOP:
  - At clk_count==CLKS_PER_BIT-1, sample rxd_s.
  - rxd_s=1: deliver the byte (see output register) -> IDLE immediately. Do not wait out the remaining half stop bit, so back-to-back frames are caught.
  - rxd_s=0: pulse frame_err for 1 cycle, discard the byte -> BREAK.
- State BREAK:
  - busy=1; stay until rxd_s=1, then -> IDLE.
  - Prevents a held-low line from producing repeated frames.
- o_rxd_busy = 1 in START, RXDATA, STOP, BREAK.
- Output register (single entry):
  - Handshake completes on the cycle where tvalid & tready are both 1; tvalid is cleared on the next edge unless a new byte loads.
  - Delivery with tvalid=0: tdata <= shift_reg, tvalid <= 1 on the cycle after the stop-sample edge.
  - Delivery with tvalid=1 & tready=1 in the same cycle: old byte consumed, new byte loaded, tvalid stays 1.
  - Delivery with tvalid=1 & tready=0: new byte dropped, tdata/tvalid unchanged, overrun pulses 1 cycle.
  - tvalid never deasserts without a handshake (except reset). tdata never changes while tvalid=1 & tready=0.
- Latency: falling edge on i_rxd to tvalid = 2 (sync) + HALF+1 + 9*CLKS_PER_BIT + 1 cycles, ±1.
- Reset mid-frame: async return to reset values; the partial byte is lost; no pulses are generated.

Decomposition:
- Shared package uart_pkg holds:
  - rx FSM state encodings (IDLE=0, START=1, RXDATA=2, STOP=3, BREAK=4, 3-bit).
  - Data width constant 8.
  - Function clks_per_bit(clk_hz, baud).
- One sub-module: uart_sync2, a 2-flop synchronizer with parameterised reset value (1 here), async active-low reset. Reusable for other async inputs.

Test Plan (CLKS_PER_BIT=16 unless stated):
- Send 0xA5 with tready=1 -> exactly one handshake with tdata=0xA5; frame_err=0, overrun=0; busy low after the stop sample.
- Send 0x00, 0xFF, 0x55 back-to-back with zero idle gap, tready=1 -> three beats with tdata 0x00, 0xFF, 0x55 in order; no errors.
- Low glitch of 5 cycles on an idle line -> FSM returns to IDLE; no tvalid, no frame_err. Then send 0x3C -> 0x3C received.
- Send 0x81 with the stop bit forced low, line held low 40 bit-times, then high, then send 0x12 -> one frame_err pulse; 0x81 not delivered; busy high during the hold; 0x12 then received.
- tready=0; send 0x11 then 0x22 -> tvalid=1 with tdata=0x11 held; one overrun pulse at 0x22 completion. Raise tready -> one beat of 0x11 only.
- Assert i_rst_n=0 during data bit 4 of 0x6B, release, send 0x9E -> tvalid drops immediately on reset; only 0x9E is delivered afterwards.
- Repeat the 0xA5 case with CLKS_PER_BIT=87 and with the bench's transmitter driving i_rxd -> 0xA5 received.
